// File: rtl/cordic_word_in_fifo.sv
// Input elastic buffer for the word-serial CORDIC: queues x/y/a samples and
// presents the head sample from registers, handing it over on din_valid & rfd.
module cordic_word_in_fifo #(
  parameter int IN_BITS  = 16,
  parameter int DEPTH    = 4,
  parameter int LOGDEPTH = 2
) (
  input  logic                clk,
  input  logic                nGrst,
  input  logic                flush,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [IN_BITS-1:0]  s_x,
  input  logic [IN_BITS-1:0]  s_y,
  input  logic [IN_BITS-1:0]  s_a,
  input  logic                rfd,
  output logic                din_valid,
  output logic [IN_BITS-1:0]  din_x,
  output logic [IN_BITS-1:0]  din_y,
  output logic [IN_BITS-1:0]  din_a,
  output logic [LOGDEPTH:0]   level,
  output logic                full,
  output logic                empty
);

  localparam int WORD_BITS = 3 * IN_BITS;
  localparam logic [LOGDEPTH:0] DEPTH_L = (LOGDEPTH + 1)'(DEPTH);

  logic [WORD_BITS-1:0] mem [DEPTH];
  logic [LOGDEPTH-1:0]  wr_ptr_reg;
  logic [LOGDEPTH-1:0]  rd_ptr_reg;
  logic [LOGDEPTH:0]    level_reg;
  logic                 head_valid_reg;
  logic [WORD_BITS-1:0] head_reg;

  logic [WORD_BITS-1:0] s_word;
  logic                 accept;
  logic                 consume;
  logic                 head_free;
  logic                 mem_empty;
  logic                 pop;
  logic                 bypass;
  logic                 push;
  logic [LOGDEPTH:0]    level_next;

  assign s_word  = {s_x, s_y, s_a};
  assign full    = (level_reg == DEPTH_L);
  assign empty   = (level_reg == '0);
  assign s_ready = ~full;
  assign accept  = s_valid & s_ready;
  assign consume = head_valid_reg & rfd;

  // The head register is part of level, so storage holds level minus the head.
  assign mem_empty = (level_reg == {{LOGDEPTH{1'b0}}, head_valid_reg});
  assign head_free = ~head_valid_reg | consume;
  assign pop       = head_free & ~mem_empty;
  assign bypass    = head_free & mem_empty & accept;
  assign push      = accept & ~bypass;

  always_comb begin
    level_next = level_reg;
    case ({accept, consume})
      2'b10:   level_next = level_reg + (LOGDEPTH + 1)'(1);
      2'b01:   level_next = level_reg - (LOGDEPTH + 1)'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      head_valid_reg <= 1'b0;
      head_reg       <= '0;
    end else if (flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      level_reg <= level_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + LOGDEPTH'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + LOGDEPTH'(1);
      end
      // Refill the head the same cycle it empties so back-to-back samples have no bubble.
      if (head_free) begin
        head_valid_reg <= pop | bypass;
        if (pop) begin
          head_reg <= mem[rd_ptr_reg];
        end else if (bypass) begin
          head_reg <= s_word;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr_reg] <= s_word;
    end
  end

  assign din_valid = head_valid_reg;
  assign din_x     = head_reg[3*IN_BITS-1:2*IN_BITS];
  assign din_y     = head_reg[2*IN_BITS-1:IN_BITS];
  assign din_a     = head_reg[IN_BITS-1:0];
  assign level     = level_reg;

endmodule
